// File: rtl/pad_window_scheduler.sv
// Raster-scan sequencer for a 3x3, pad-1 window: emits anchor (row, col) and tap-valid mask.
// Optional stride-2 support is built only when PAD_STRIDE2_EN is defined.
module pad_window_scheduler #(
    parameter int unsigned DIM_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [DIM_W-1:0] i_height,
    input  logic [DIM_W-1:0] i_width,
    input  logic             i_stride2,
    input  logic             i_ready,
    output logic             o_valid,
    output logic [DIM_W-1:0] o_row,
    output logic [DIM_W-1:0] o_col,
    output logic [8:0]       o_sel,
    output logic             o_last,
    output logic             o_busy,
    output logic             o_done
);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e           state_q, state_d;
    logic [DIM_W-1:0] h_q, h_d;
    logic [DIM_W-1:0] w_q, w_d;
    logic [DIM_W-1:0] row_q, row_d;
    logic [DIM_W-1:0] col_q, col_d;
    logic [8:0]       sel_q, sel_d;

    logic [DIM_W:0]   step;
    logic [DIM_W:0]   row_nxt;
    logic [DIM_W:0]   col_nxt;
    logic             col_wrap;
    logic             at_last;
    logic             start_ok;

    // Tap (r, c) hits input (row + r - 1, col + c - 1); shifting by +1 keeps it unsigned,
    // so the valid range becomes [1, dim].
    function automatic logic [8:0] tap_mask(input logic [DIM_W-1:0] row,
                                            input logic [DIM_W-1:0] col,
                                            input logic [DIM_W-1:0] h,
                                            input logic [DIM_W-1:0] w);
        logic [DIM_W+1:0] rr;
        logic [DIM_W+1:0] cc;
        logic [8:0]       m;
        m = '0;
        for (int k = 0; k < 9; k++) begin
            rr   = {2'b00, row} + (DIM_W+2)'(k / 3);
            cc   = {2'b00, col} + (DIM_W+2)'(k % 3);
            m[k] = (rr != '0) && (rr <= {2'b00, h}) && (cc != '0) && (cc <= {2'b00, w});
        end
        return m;
    endfunction

`ifdef PAD_STRIDE2_EN
    logic stride_q, stride_d;

    assign step = stride_q ? (DIM_W+1)'(2) : (DIM_W+1)'(1);

    always_comb begin
        stride_d = stride_q;
        if (state_q == StIdle && start_ok) begin
            stride_d = i_stride2;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            stride_q <= 1'b0;
        end else begin
            stride_q <= stride_d;
        end
    end
`else
    logic unused_stride2;

    assign step           = (DIM_W+1)'(1);
    assign unused_stride2 = i_stride2;
`endif

    assign start_ok = i_start && (i_height != '0) && (i_width != '0);
    assign row_nxt  = {1'b0, row_q} + step;
    assign col_nxt  = {1'b0, col_q} + step;
    assign col_wrap = col_nxt >= {1'b0, w_q};
    assign at_last  = col_wrap && (row_nxt >= {1'b0, h_q});

    always_comb begin
        state_d = state_q;
        h_d     = h_q;
        w_d     = w_q;
        row_d   = row_q;
        col_d   = col_q;
        sel_d   = sel_q;
        unique case (state_q)
            StIdle: begin
                if (start_ok) begin
                    state_d = StRun;
                    h_d     = i_height;
                    w_d     = i_width;
                    row_d   = '0;
                    col_d   = '0;
                    sel_d   = tap_mask('0, '0, i_height, i_width);
                end
            end
            StRun: begin
                if (i_ready) begin
                    if (at_last) begin
                        state_d = StDone;
                    end else if (col_wrap) begin
                        col_d = '0;
                        row_d = row_nxt[DIM_W-1:0];
                    end else begin
                        col_d = col_nxt[DIM_W-1:0];
                    end
                    sel_d = tap_mask(row_d, col_d, h_q, w_q);
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= StIdle;
            h_q     <= '0;
            w_q     <= '0;
            row_q   <= '0;
            col_q   <= '0;
            sel_q   <= '0;
        end else begin
            state_q <= state_d;
            h_q     <= h_d;
            w_q     <= w_d;
            row_q   <= row_d;
            col_q   <= col_d;
            sel_q   <= sel_d;
        end
    end

    assign o_valid = (state_q == StRun);
    assign o_busy  = (state_q == StRun);
    assign o_done  = (state_q == StDone);
    assign o_last  = o_valid && at_last;
    assign o_row   = row_q;
    assign o_col   = col_q;
    assign o_sel   = sel_q;

endmodule

// File: tb/tb_pad_window_scheduler.sv
// Scoreboard bench for pad_window_scheduler: stimulus pushes expected positions,
// a negedge monitor pops and compares on every handshake.
module tb_pad_window_scheduler;

    localparam int DW = 8;

    logic          i_clk = 1'b0;
    logic          i_rst;
    logic          i_start;
    logic [DW-1:0] i_height;
    logic [DW-1:0] i_width;
    logic          i_stride2;
    logic          i_ready;
    logic          o_valid;
    logic [DW-1:0] o_row;
    logic [DW-1:0] o_col;
    logic [8:0]    o_sel;
    logic          o_last;
    logic          o_busy;
    logic          o_done;

    typedef struct packed {
        logic [DW-1:0] row;
        logic [DW-1:0] col;
        logic [8:0]    sel;
        logic          last;
    } exp_t;

    typedef struct {
        int h;
        int w;
        int row;
        int col;
        int sel;
    } hand_t;

    exp_t  exp_q[$];
    hand_t hand[7];
    int    n_vec    = 0;
    int    n_mis    = 0;
    int    hs_count = 0;
    int    done_cnt = 0;
    int    cur_h    = 0;
    int    cur_w    = 0;

    pad_window_scheduler #(
        .DIM_W(DW)
    ) dut (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_start  (i_start),
        .i_height (i_height),
        .i_width  (i_width),
        .i_stride2(i_stride2),
        .i_ready  (i_ready),
        .o_valid  (o_valid),
        .o_row    (o_row),
        .o_col    (o_col),
        .o_sel    (o_sel),
        .o_last   (o_last),
        .o_busy   (o_busy),
        .o_done   (o_done)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected positions from a plain signed-integer reference of the padded window.
    task automatic push_run(input int h, input int w, input int s, output int n);
        exp_t       e;
        logic [8:0] m;
        int         rr;
        int         cc;
        n = 0;
        for (int r = 0; r < h; r += s) begin
            for (int c = 0; c < w; c += s) begin
                m = '0;
                for (int k = 0; k < 9; k++) begin
                    rr   = r + k / 3 - 1;
                    cc   = c + k % 3 - 1;
                    m[k] = (rr >= 0) && (rr < h) && (cc >= 0) && (cc < w);
                end
                e.row  = DW'(r);
                e.col  = DW'(c);
                e.sel  = m;
                e.last = (r + s >= h) && (c + s >= w);
                exp_q.push_back(e);
                n++;
            end
        end
    endtask

    task automatic start_pulse(input int h, input int w, input logic s2);
        @(posedge i_clk);
        #1;
        i_height  = DW'(h);
        i_width   = DW'(w);
        i_stride2 = s2;
        i_start   = 1'b1;
        @(posedge i_clk);
        #1;
        i_start = 1'b0;
    endtask

    // mode 0: ready held high; mode 1: ready pattern 1,0,0,1,0,0,...
    task automatic run(input int h, input int w, input logic s2, input int mode,
                       input logic mid_start);
        int s;
        int n;
        int base_hs;
        int base_done;
        int busy_cyc;
        int cyc;
`ifdef PAD_STRIDE2_EN
        s = s2 ? 2 : 1;
`else
        s = 1;
`endif
        push_run(h, w, s, n);
        cur_h     = h;
        cur_w     = w;
        base_hs   = hs_count;
        base_done = done_cnt;
        i_ready   = 1'b1;
        start_pulse(h, w, s2);
        @(negedge i_clk);
        check("start_latency_valid", int'(o_valid), 1);
        check("start_latency_busy", int'(o_busy), 1);
        busy_cyc = int'(o_busy);
        cyc      = 0;
        while (done_cnt == base_done && cyc < 500) begin
            @(posedge i_clk);
            #1;
            cyc++;
            if (mode == 1) i_ready = (cyc % 3 == 0);
            if (mid_start && cyc == 4) begin
                i_height = DW'(7);
                i_width  = DW'(2);
            end
            i_start = mid_start && (cyc == 4);
            @(negedge i_clk);
            if (o_busy) busy_cyc++;
        end
        i_ready = 1'b1;
        i_start = 1'b0;
        check("run_completed", int'(done_cnt > base_done), 1);
        check("handshake_count", hs_count - base_hs, n);
        check("queue_drained", exp_q.size(), 0);
        if (mode == 0) check("no_bubbles", busy_cyc, n);
    endtask

    // Monitor: compares on every handshake, checks stall stability and the done pulse.
    initial begin
        exp_t          e;
        logic          exp_done;
        logic          stall_chk;
        logic [DW-1:0] s_row;
        logic [DW-1:0] s_col;
        logic [8:0]    s_sel;
        logic          s_last;
        exp_done  = 1'b0;
        stall_chk = 1'b0;
        forever begin
            @(negedge i_clk);
            if (i_rst) begin
                exp_done  = 1'b0;
                stall_chk = 1'b0;
            end else begin
                check("done_pulse", int'(o_done), int'(exp_done));
                if (exp_done) check("busy_after_last", int'(o_busy), 0);
                exp_done = 1'b0;
                if (o_done) done_cnt++;
                if (stall_chk) begin
                    check("stall_valid", int'(o_valid), 1);
                    check("stall_row", int'(o_row), int'(s_row));
                    check("stall_col", int'(o_col), int'(s_col));
                    check("stall_sel", int'(o_sel), int'(s_sel));
                    check("stall_last", int'(o_last), int'(s_last));
                end
                stall_chk = 1'b0;
                if (o_valid && i_ready) begin
                    hs_count++;
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_mis++;
                        $display("FAIL extra_position: got (%0d,%0d), expected none",
                                 o_row, o_col);
                    end else begin
                        e = exp_q.pop_front();
                        check("pos_row", int'(o_row), int'(e.row));
                        check("pos_col", int'(o_col), int'(e.col));
                        check("pos_sel", int'(o_sel), int'(e.sel));
                        check("pos_last", int'(o_last), int'(e.last));
                        exp_done = e.last;
                    end
                    for (int i = 0; i < 7; i++) begin
                        if (hand[i].h == cur_h && hand[i].w == cur_w &&
                            hand[i].row == int'(o_row) && hand[i].col == int'(o_col)) begin
                            check("hand_sel", int'(o_sel), hand[i].sel);
                        end
                    end
                end else if (o_valid) begin
                    s_row     = o_row;
                    s_col     = o_col;
                    s_sel     = o_sel;
                    s_last    = o_last;
                    stall_chk = 1'b1;
                end
            end
        end
    end

    initial begin
        int n;
        int base_hs;
        hand[0] = '{4, 4, 0, 0, 'h1B0};
        hand[1] = '{4, 4, 1, 1, 'h1FF};
        hand[2] = '{4, 4, 0, 3, 'h0D8};
        hand[3] = '{4, 4, 3, 3, 'h01B};
        hand[4] = '{1, 1, 0, 0, 'h010};
        hand[5] = '{3, 3, 1, 0, 'h1B6};
        hand[6] = '{5, 5, 4, 4, 'h01B};

        i_rst     = 1'b1;
        i_start   = 1'b0;
        i_height  = '0;
        i_width   = '0;
        i_stride2 = 1'b0;
        i_ready   = 1'b1;
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        check("rst_valid", int'(o_valid), 0);
        check("rst_busy", int'(o_busy), 0);
        check("rst_done", int'(o_done), 0);
        check("rst_last", int'(o_last), 0);
        check("rst_row", int'(o_row), 0);
        check("rst_col", int'(o_col), 0);
        check("rst_sel", int'(o_sel), 0);
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;

        run(4, 4, 1'b0, 0, 1'b0);
        run(1, 1, 1'b0, 0, 1'b0);
        run(3, 3, 1'b0, 1, 1'b1);
        run(5, 5, 1'b1, 0, 1'b0);

        // Zero-width start must be ignored.
        start_pulse(3, 0, 1'b0);
        repeat (3) begin
            @(negedge i_clk);
            check("w0_valid", int'(o_valid), 0);
            check("w0_busy", int'(o_busy), 0);
        end

        // Reset after five handshakes aborts the run with no done pulse.
        cur_h   = 4;
        cur_w   = 4;
        base_hs = hs_count;
        push_run(4, 4, 1, n);
        start_pulse(4, 4, 1'b0);
        for (int i = 0; i < 100 && hs_count < base_hs + 5; i++) @(negedge i_clk);
        check("rst_run_progress", int'(hs_count >= base_hs + 5), 1);
        @(posedge i_clk);
        #1;
        i_rst = 1'b1;
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        exp_q.delete();
        repeat (3) begin
            @(negedge i_clk);
            check("abort_valid", int'(o_valid), 0);
            check("abort_busy", int'(o_busy), 0);
            check("abort_done", int'(o_done), 0);
        end

        run(2, 3, 1'b0, 0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
